rmii_tx_arbiter: RTL and testbench
==================================

// Module: rmii_tx_arbiter
// PURPOSE
//  Two-requester round-robin scheduler for the MAC byte-wide TX interface of the RMII bridge.
//  Grants one whole frame at a time and drives mac_txd/mac_tx_en/mac_tx_er.
//  Enforces a minimum inter-frame gap, a maximum frame length and source-underrun handling.
//  Runs in the mac_tx_clk (byte clock) domain, between the frame sources and the RMII block.
// PARAMETERS
//  IFG_BYTES  12    idle byte-clocks forced after every frame (>=1)
//  MAX_BYTES  1522  max bytes per grant; longer frames truncated with error
//  CNT_W      11    width of byte/gap counters; 2**CNT_W > MAX_BYTES
// PORTS
//  clock       in   1  byte clock (mac_tx_clk); all logic on posedge
//  reset       in   1  synchronous, active-low reset (0 = reset)
//  req0/req1   in   1  source i has a valid byte on data_i (level, held for whole frame)
//  data0/data1 in   8  byte from source i
//  last0/last1 in   1  byte on data_i is final byte of frame
//  ack0/ack1   out  1  combinational: byte on data_i consumed this edge; source advances
//  mac_col     in   1  collision indication from RMII block
//  mac_txd     out  8  registered byte to RMII block
//  mac_tx_en   out  1  registered frame-active strobe
//  mac_tx_er   out  1  registered error strobe
//  grant       out  1  index of current/last granted source
//  busy        out  1  state != IDLE
//  err_underrun out 1  one-cycle pulse: granted source dropped req before last
//  err_toolong  out 1  one-cycle pulse: frame truncated at MAX_BYTES
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, mac_txd=0, mac_tx_en=0, mac_tx_er=0, grant=1
//   (so source 0 wins first tie), counters=0, all pulses 0; ack0/ack1=0 while reset==0.
//  Reset mid-frame aborts immediately; outputs return to reset values next edge, no IFG.
//  FSM: IDLE -> SEND -> GAP -> IDLE.
//  IDLE: if any req: grant <= requester; both requesting -> ~grant (round robin); -> SEND.
//   No ack in IDLE; first byte is taken in SEND (1-cycle grant latency).
//  SEND: ack_grant = req_grant; on that edge mac_txd<=data_grant, mac_tx_en<=1, count++.
//   last_grant & req_grant -> GAP after this byte.
//   req_grant==0 (underrun): mac_tx_en<=1, mac_tx_er<=1, mac_txd<=0 for one byte,
//    err_underrun pulse, -> GAP.
//   count reaches MAX_BYTES without last: that byte sent with mac_tx_er=1, err_toolong
//    pulse, -> GAP; source must discard remainder (no further ack this frame).
//   Non-granted source never acked; its req is ignored until next IDLE.
//  GAP: mac_tx_en=0, mac_tx_er=0, mac_txd=0 for exactly IFG_BYTES cycles, then IDLE.
//   Gap counter counts from 0 to IFG_BYTES-1; both counters clear on entry to SEND/GAP.
//  Frame latency: req to first mac_tx_en = 2 edges; end of frame to next mac_tx_en
//   >= IFG_BYTES+1 idle cycles (IDLE grant cycle included).
//  1-byte frame (last on first byte) legal: one mac_tx_en cycle.
//  mac_col ignored unless RMII_TX_ARB_COL_ABORT_EN defined.
// CONFIGURATION
//  RMII_TX_ARB_COL_ABORT_EN defined: mac_col==1 in SEND -> current byte sent with
//   mac_tx_er=1, ack_grant still asserted, state -> GAP; grant is NOT advanced, so the
//   same source is re-granted first on next IDLE (retry); extra output col_abort pulses.
//  Undefined: mac_col unused, no col_abort port, frames always run to last/underrun/max.
// TESTING
//  T1 reset=0 3 cycles with req0=1 -> ack0=0, mac_tx_en=0, mac_txd=0, grant=1 throughout.
//  T2 req0 only, 64-byte frame 0x00..0x3F -> mac_txd 0x00..0x3F on 64 consecutive
//     mac_tx_en cycles, first 2 edges after req0; then 12 idle cycles min.
//  T3 req0 and req1 held, 2 frames each -> grant order 0,1,0,1; every gap >= 12 cycles.
//  T4 req1 drops after byte 10 without last -> byte 11 has mac_tx_er=1, mac_txd=0;
//     err_underrun pulse; 12-cycle GAP.
//  T5 MAX_BYTES=16, 20-byte frame -> 16 bytes sent, byte 16 with mac_tx_er=1,
//     err_toolong pulse, ack stops after 16.
//  T6 (COL_ABORT_EN) mac_col=1 at byte 5 of source 0, req1 pending -> byte 5 has
//     mac_tx_er=1, GAP, next grant = source 0.

Source files
------------

// File: rtl/rmii_tx_arbiter_if.sv
// Source/MAC bus of the RMII TX arbiter: two frame sources in, one byte stream out.
// Optional col_abort strobe exists only when RMII_TX_ARB_COL_ABORT_EN is defined.
interface rmii_tx_arbiter_if;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       last0, last1;
  logic       ack0, ack1;
  logic       mac_col;
  logic [7:0] mac_txd;
  logic       mac_tx_en, mac_tx_er;
  logic       grant, busy, err_underrun, err_toolong;
`ifdef RMII_TX_ARB_COL_ABORT_EN
  logic       col_abort;
`endif

  modport master (
    output req0, req1, data0, data1, last0, last1, mac_col,
`ifdef RMII_TX_ARB_COL_ABORT_EN
    input  col_abort,
`endif
    input  ack0, ack1, mac_txd, mac_tx_en, mac_tx_er, grant, busy,
    input  err_underrun, err_toolong
  );

  modport slave (
    input  req0, req1, data0, data1, last0, last1, mac_col,
`ifdef RMII_TX_ARB_COL_ABORT_EN
    output col_abort,
`endif
    output ack0, ack1, mac_txd, mac_tx_en, mac_tx_er, grant, busy,
    output err_underrun, err_toolong
  );
endinterface

// File: rtl/rmii_tx_arbiter.sv
// Round-robin frame scheduler for the byte-wide MAC TX path: IFG, max length, underrun.
// Define RMII_TX_ARB_COL_ABORT_EN to abort on mac_col and retry the same source.
module rmii_tx_arbiter #(
  parameter int IFG_BYTES = 12,
  parameter int MAX_BYTES = 1522,
  parameter int CNT_W     = 11
) (
  input logic              clock,
  input logic              reset,
  rmii_tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(MAX_BYTES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(IFG_BYTES - 1);

  state_t           state, state_nxt;
  logic             grant, grant_nxt;
  logic             retry, retry_nxt;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [7:0]       txd, txd_nxt;
  logic             tx_en, tx_en_nxt;
  logic             tx_er, tx_er_nxt;
  logic             underrun, underrun_nxt;
  logic             toolong, toolong_nxt;
  logic             col_nxt;
  logic             col_hit;
  logic             req_g, last_g, ack_g;
  logic [7:0]       data_g;

  assign req_g  = grant ? bus.req1  : bus.req0;
  assign last_g = grant ? bus.last1 : bus.last0;
  assign data_g = grant ? bus.data1 : bus.data0;

  // Sources only advance while out of reset and actually streaming a frame.
  assign ack_g    = reset && (state == SEND) && req_g;
  assign bus.ack0 = ack_g && !grant;
  assign bus.ack1 = ack_g &&  grant;

`ifdef RMII_TX_ARB_COL_ABORT_EN
  assign col_hit = bus.mac_col;
`else
  logic unused_col;
  assign col_hit    = 1'b0;
  assign unused_col = bus.mac_col;
`endif

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    retry_nxt    = retry;
    byte_cnt_nxt = byte_cnt;
    gap_cnt_nxt  = gap_cnt;
    txd_nxt      = '0;
    tx_en_nxt    = 1'b0;
    tx_er_nxt    = 1'b0;
    underrun_nxt = 1'b0;
    toolong_nxt  = 1'b0;
    col_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt    = SEND;
          byte_cnt_nxt = '0;
          gap_cnt_nxt  = '0;
          retry_nxt    = 1'b0;
          // A collided source keeps its turn; otherwise alternate on contention.
          if (retry && req_g)
            grant_nxt = grant;
          else if (bus.req0 && bus.req1)
            grant_nxt = ~grant;
          else
            grant_nxt = bus.req1;
        end
      end
      SEND: begin
        tx_en_nxt = 1'b1;
        if (!req_g) begin
          tx_er_nxt    = 1'b1;
          underrun_nxt = 1'b1;
          state_nxt    = GAP;
          byte_cnt_nxt = '0;
          gap_cnt_nxt  = '0;
        end else begin
          txd_nxt      = data_g;
          byte_cnt_nxt = byte_cnt + 1'b1;
          if (col_hit) begin
            tx_er_nxt    = 1'b1;
            col_nxt      = 1'b1;
            retry_nxt    = 1'b1;
            state_nxt    = GAP;
            byte_cnt_nxt = '0;
            gap_cnt_nxt  = '0;
          end else if (last_g) begin
            state_nxt    = GAP;
            byte_cnt_nxt = '0;
            gap_cnt_nxt  = '0;
          end else if (byte_cnt == BYTE_LAST) begin
            tx_er_nxt    = 1'b1;
            toolong_nxt  = 1'b1;
            state_nxt    = GAP;
            byte_cnt_nxt = '0;
            gap_cnt_nxt  = '0;
          end
        end
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant resets to 1 so that source 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= 1'b1;
      retry    <= 1'b0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      txd      <= '0;
      tx_en    <= 1'b0;
      tx_er    <= 1'b0;
      underrun <= 1'b0;
      toolong  <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      retry    <= retry_nxt;
      byte_cnt <= byte_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      txd      <= txd_nxt;
      tx_en    <= tx_en_nxt;
      tx_er    <= tx_er_nxt;
      underrun <= underrun_nxt;
      toolong  <= toolong_nxt;
    end
  end

`ifdef RMII_TX_ARB_COL_ABORT_EN
  logic col_abort;
  always_ff @(posedge clock) begin
    if (!reset) col_abort <= 1'b0;
    else        col_abort <= col_nxt;
  end
  assign bus.col_abort = col_abort;
`else
  logic unused_col_nxt;
  assign unused_col_nxt = col_nxt;
`endif

  assign bus.mac_txd      = txd;
  assign bus.mac_tx_en    = tx_en;
  assign bus.mac_tx_er    = tx_er;
  assign bus.grant        = grant;
  assign bus.busy         = (state != IDLE);
  assign bus.err_underrun = underrun;
  assign bus.err_toolong  = toolong;
endmodule

// File: tb/tb_rmii_tx_arbiter.sv
// Directed bench for rmii_tx_arbiter: a default instance plus a MAX_BYTES=16 instance
// sharing the same sources; col-abort expectations follow RMII_TX_ARB_COL_ABORT_EN.
module tb_rmii_tx_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rmii_tx_arbiter_if bus ();
  rmii_tx_arbiter_if bus_m ();

  rmii_tx_arbiter #(.IFG_BYTES(12), .MAX_BYTES(1522), .CNT_W(11)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  rmii_tx_arbiter #(.IFG_BYTES(12), .MAX_BYTES(16), .CNT_W(11)) dut_m (
    .clock(clock), .reset(reset), .bus(bus_m));

  assign bus_m.req0    = bus.req0;
  assign bus_m.req1    = bus.req1;
  assign bus_m.data0   = bus.data0;
  assign bus_m.data1   = bus.data1;
  assign bus_m.last0   = bus.last0;
  assign bus_m.last1   = bus.last1;
  assign bus_m.mac_col = bus.mac_col;

  typedef struct packed {
    logic       en, er, busy, grant, und, lng, cab;
    logic [7:0] txd;
  } smp_t;

  int         checks = 0;
  int         errors = 0;
  int         len[2], idx[2], nfr[2], drop_at[2], ack_cnt[2];
  logic [7:0] base[2];
  bit         col_arm, sel;
  logic       a0, a1;
  smp_t       log_q[$];
  int         rs[$], rl[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    logic       r[2];
    logic [7:0] d[2];
    logic       l[2];
    for (int i = 0; i < 2; i++) begin
      r[i] = (nfr[i] > 0) && !(drop_at[i] >= 0 && idx[i] >= drop_at[i]);
      d[i] = r[i] ? base[i] + 8'(idx[i]) : 8'h00;
      l[i] = r[i] && (idx[i] == len[i] - 1);
    end
    bus.req0    = r[0];
    bus.req1    = r[1];
    bus.data0   = d[0];
    bus.data1   = d[1];
    bus.last0   = l[0];
    bus.last1   = l[1];
    bus.mac_col = col_arm && r[0] && (idx[0] == 4);
  endtask

  task automatic adv(int i);
    idx[i]++;
    if (idx[i] == len[i]) begin
      idx[i] = 0;
      nfr[i]--;
    end
  endtask

  task automatic cycle();
    smp_t s;
    @(negedge clock);
    a0 = sel ? bus_m.ack0 : bus.ack0;
    a1 = sel ? bus_m.ack1 : bus.ack1;
    @(posedge clock);
    #1;
    s.en    = sel ? bus_m.mac_tx_en    : bus.mac_tx_en;
    s.er    = sel ? bus_m.mac_tx_er    : bus.mac_tx_er;
    s.busy  = sel ? bus_m.busy         : bus.busy;
    s.grant = sel ? bus_m.grant        : bus.grant;
    s.und   = sel ? bus_m.err_underrun : bus.err_underrun;
    s.lng   = sel ? bus_m.err_toolong  : bus.err_toolong;
    s.txd   = sel ? bus_m.mac_txd      : bus.mac_txd;
`ifdef RMII_TX_ARB_COL_ABORT_EN
    s.cab   = bus.col_abort;
`else
    s.cab   = 1'b0;
`endif
    log_q.push_back(s);
    if (a0 === 1'b1) begin ack_cnt[0]++; adv(0); end
    if (a1 === 1'b1) begin ack_cnt[1]++; adv(1); end
    // A truncated frame's remainder is discarded; a collided frame restarts.
    if (s.lng === 1'b1) nfr[s.grant] = 0;
    if (s.cab === 1'b1) begin idx[s.grant] = 0; col_arm = 0; end
    drive_src();
  endtask

  task automatic reset_dut();
    reset   = 1'b0;
    nfr     = '{0, 0};
    idx     = '{0, 0};
    drop_at = '{-1, -1};
    col_arm = 0;
    sel     = 0;
    drive_src();
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b1;
    log_q.delete();
    ack_cnt = '{0, 0};
  endtask

  task automatic find_runs();
    rs.delete();
    rl.delete();
    for (int k = 0; k < log_q.size(); k++) begin
      if (log_q[k].en === 1'b1) begin
        if (k == 0 || log_q[k-1].en !== 1'b1) begin
          rs.push_back(k);
          rl.push_back(1);
        end else begin
          rl[rl.size()-1]++;
        end
      end
    end
  endtask

  function automatic int run_s(int k);
    return (k < rs.size()) ? rs[k] : -1;
  endfunction

  function automatic int run_l(int k);
    return (k < rl.size()) ? rl[k] : -1;
  endfunction

  function automatic smp_t at(int k);
    smp_t z;
    z = 'x;
    if (k >= 0 && k < log_q.size()) z = log_q[k];
    return z;
  endfunction

  function automatic int cnt(int f);
    int n = 0;
    foreach (log_q[k]) begin
      case (f)
        0: n += (log_q[k].er  === 1'b1) ? 1 : 0;
        1: n += (log_q[k].und === 1'b1) ? 1 : 0;
        2: n += (log_q[k].lng === 1'b1) ? 1 : 0;
        default: n += (log_q[k].cab === 1'b1) ? 1 : 0;
      endcase
    end
    return n;
  endfunction

  initial begin
    // T1: reset held with a pending request
    nfr = '{1, 0}; len = '{4, 4}; idx = '{0, 0}; drop_at = '{-1, -1};
    base = '{8'h00, 8'h00}; col_arm = 0; sel = 0; ack_cnt = '{0, 0};
    drive_src();
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("t1_ack0",  32'(a0), 32'd0);
      check("t1_en",    32'(at(log_q.size()-1).en),    32'd0);
      check("t1_txd",   32'(at(log_q.size()-1).txd),   32'd0);
      check("t1_grant", 32'(at(log_q.size()-1).grant), 32'd1);
    end

    // T2: single 64-byte frame from source 0
    reset_dut();
    len[0] = 64; base[0] = 8'h00; nfr[0] = 1;
    drive_src();
    repeat (100) cycle();
    find_runs();
    check("t2_runs",  32'(rs.size()), 32'd1);
    check("t2_start", 32'(run_s(0)), 32'd1);
    check("t2_len",   32'(run_l(0)), 32'd64);
    for (int k = 0; k < 64; k++) check("t2_txd", 32'(at(1 + k).txd), 32'(k));
    check("t2_er",     32'(cnt(0)), 32'd0);
    check("t2_grant",  32'(at(1).grant), 32'd0);
    check("t2_gapend", 32'(at(75).busy), 32'd1);
    check("t2_idle",   32'(at(76).busy), 32'd0);
    check("t2_acks",   32'(ack_cnt[0]), 32'd64);

    // T3: both sources, two 4-byte frames each
    reset_dut();
    len = '{4, 4}; base = '{8'h10, 8'h80}; nfr = '{2, 2};
    drive_src();
    repeat (100) cycle();
    find_runs();
    check("t3_runs", 32'(rs.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("t3_grant", 32'(at(run_s(k)).grant), 32'(k % 2));
      check("t3_first", 32'(at(run_s(k)).txd), (k % 2) ? 32'h80 : 32'h10);
      check("t3_len",   32'(run_l(k)), 32'd4);
    end
    for (int k = 0; k < 3; k++)
      check("t3_gap", 32'(run_s(k + 1) - run_s(k) - run_l(k)), 32'd13);

    // T4: source 1 underruns after 10 bytes
    reset_dut();
    len[1] = 20; base[1] = 8'h30; nfr[1] = 1; drop_at[1] = 10;
    drive_src();
    repeat (40) cycle();
    find_runs();
    check("t4_runs", 32'(rs.size()), 32'd1);
    check("t4_len",  32'(run_l(0)), 32'd11);
    for (int k = 0; k < 10; k++) check("t4_txd", 32'(at(1 + k).txd), 32'h30 + 32'(k));
    check("t4_er11",   32'(at(11).er),  32'd1);
    check("t4_txd11",  32'(at(11).txd), 32'd0);
    check("t4_und11",  32'(at(11).und), 32'd1);
    check("t4_undcnt", 32'(cnt(1)), 32'd1);
    check("t4_ercnt",  32'(cnt(0)), 32'd1);
    check("t4_gapend", 32'(at(22).busy), 32'd1);
    check("t4_idle",   32'(at(23).busy), 32'd0);
    check("t4_acks",   32'(ack_cnt[1]), 32'd10);

    // T5: MAX_BYTES=16 instance, 20-byte frame
    reset_dut();
    sel = 1;
    len[0] = 20; base[0] = 8'h40; nfr[0] = 1;
    drive_src();
    repeat (40) cycle();
    find_runs();
    check("t5_runs",   32'(rs.size()), 32'd1);
    check("t5_len",    32'(run_l(0)), 32'd16);
    check("t5_first",  32'(at(1).txd), 32'h40);
    check("t5_txd16",  32'(at(16).txd), 32'h4f);
    check("t5_er16",   32'(at(16).er), 32'd1);
    check("t5_ercnt",  32'(cnt(0)), 32'd1);
    check("t5_lng16",  32'(at(16).lng), 32'd1);
    check("t5_lngcnt", 32'(cnt(2)), 32'd1);
    check("t5_undcnt", 32'(cnt(1)), 32'd0);
    check("t5_acks",   32'(ack_cnt[0]), 32'd16);

    // T6: mac_col on byte 5 of source 0 with source 1 pending
    reset_dut();
    len = '{8, 3}; base = '{8'h20, 8'ha0}; nfr = '{1, 1}; col_arm = 1;
    drive_src();
    repeat (70) cycle();
    find_runs();
`ifdef RMII_TX_ARB_COL_ABORT_EN
    check("t6_runs",    32'(rs.size()), 32'd3);
    check("t6_len0",    32'(run_l(0)), 32'd5);
    check("t6_grant0",  32'(at(run_s(0)).grant), 32'd0);
    check("t6_er5",     32'(at(5).er), 32'd1);
    check("t6_txd5",    32'(at(5).txd), 32'h24);
    check("t6_cabcnt",  32'(cnt(3)), 32'd1);
    check("t6_grant1",  32'(at(run_s(1)).grant), 32'd0);
    check("t6_first1",  32'(at(run_s(1)).txd), 32'h20);
    check("t6_len1",    32'(run_l(1)), 32'd8);
    check("t6_grant2",  32'(at(run_s(2)).grant), 32'd1);
    check("t6_len2",    32'(run_l(2)), 32'd3);
`else
    check("t6_runs",    32'(rs.size()), 32'd2);
    check("t6_len0",    32'(run_l(0)), 32'd8);
    check("t6_grant0",  32'(at(run_s(0)).grant), 32'd0);
    check("t6_ercnt",   32'(cnt(0)), 32'd0);
    check("t6_grant1",  32'(at(run_s(1)).grant), 32'd1);
    check("t6_first1",  32'(at(run_s(1)).txd), 32'ha0);
    check("t6_len1",    32'(run_l(1)), 32'd3);
    check("t6_gap",     32'(run_s(1) - run_s(0) - run_l(0)), 32'd13);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
